// File: rtl/led_shift_driver_pkg.sv
// Shared definitions for the LED shift driver: FSM state encoding and
// default parameter values used by the top level and the tick divider.
package led_shift_driver_pkg;

    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned DEF_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT_LOW  = 2'd1,
        SHIFT_HIGH = 2'd2,
        LATCH      = 2'd3
    } state_e;

endpackage

// File: rtl/led_shift_driver_tick_divider.sv
// tick_divider: half-period timer for the serial clock.
//   Clock  - system clock
//   Reset  - asynchronous, active-low reset
//   iClear - synchronous clear; holds the count at zero
//   oTick  - high in the last cycle of every CLK_DIV-cycle period
module tick_divider
    import led_shift_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iClear,
    output logic oTick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign oTick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (iClear || oTick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_driver.sv
// led_shift_driver: serialises the LED register to an external
// serial-in/parallel-out shift register whenever its value changes.
//   Clock    - system clock, rising edge
//   Reset    - asynchronous, active-low reset
//   iData    - LED value to mirror externally
//   oSerClk  - shift clock to the external register
//   oSerData - serial data, MSB first
//   oLatch   - storage-register latch strobe, active-high
//   oBusy    - high while a transfer is in progress
//   oDone    - one-cycle pulse when a transfer finishes
module led_shift_driver
    import led_shift_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned WIDTH   = DEF_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] iData,
    output logic             oSerClk,
    output logic             oSerData,
    output logic             oLatch,
    output logic             oBusy,
    output logic             oDone
);

    localparam int unsigned    BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sent_q, sent_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             force_q, force_d;
    logic             ser_clk_q, ser_clk_d;
    logic             ser_data_q, ser_data_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             div_clear;

    // Divider is held at zero while idle so every phase starts on a fresh count.
    assign div_clear = (state_q == IDLE);

    tick_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_divider (
        .Clock (Clock),
        .Reset (Reset),
        .iClear(div_clear),
        .oTick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        sent_d    = sent_q;
        bit_cnt_d = bit_cnt_q;
        force_d   = force_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (force_q || (iData != sent_q)) begin
                    shift_d   = iData;
                    sent_d    = iData;
                    force_d   = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT_LOW;
                end
            end
            SHIFT_LOW: begin
                if (tick) begin
                    state_d = SHIFT_HIGH;
                end
            end
            SHIFT_HIGH: begin
                if (tick) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    state_d   = (bit_cnt_d == BITS_LAST) ? LATCH : SHIFT_LOW;
                end
            end
            LATCH: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with state_q and never see iData combinationally.
        ser_clk_d = (state_d == SHIFT_HIGH);
        latch_d   = (state_d == LATCH);
        busy_d    = (state_d != IDLE);
        case (state_d)
            SHIFT_LOW:  ser_data_d = shift_d[WIDTH-1];
            SHIFT_HIGH: ser_data_d = ser_data_q;
            default:    ser_data_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            sent_q     <= '0;
            bit_cnt_q  <= '0;
            force_q    <= 1'b1;
            ser_clk_q  <= 1'b0;
            ser_data_q <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            sent_q     <= sent_d;
            bit_cnt_q  <= bit_cnt_d;
            force_q    <= force_d;
            ser_clk_q  <= ser_clk_d;
            ser_data_q <= ser_data_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign oSerClk  = ser_clk_q;
    assign oSerData = ser_data_q;
    assign oLatch   = latch_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_led_shift_driver.sv
module tb_led_shift_driver;

    localparam int CD   = 4;
    localparam int W    = 8;
    localparam int XFER = (2 * W + 1) * CD;

    typedef struct {
        logic [7:0] word;
        int         nbits;
        int         busy_len;
        int         latch_len;
        int         latch_pulses;
    } rec_t;

    logic       Clock = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data  = 8'h00;
    logic       sclk, sdata, latch, busy, done;

    logic       rst1_n = 1'b1;
    logic [7:0] data1  = 8'hFF;
    logic       sclk1, sdata1, latch1, busy1, done1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 Clock = ~Clock;

    led_shift_driver #(.CLK_DIV(CD), .WIDTH(W)) dut (
        .Clock(Clock), .Reset(rst_n), .iData(data),
        .oSerClk(sclk), .oSerData(sdata), .oLatch(latch), .oBusy(busy), .oDone(done)
    );

    led_shift_driver #(.CLK_DIV(1), .WIDTH(W)) dut1 (
        .Clock(Clock), .Reset(rst1_n), .iData(data1),
        .oSerClk(sclk1), .oSerData(sdata1), .oLatch(latch1), .oBusy(busy1), .oDone(done1)
    );

    // Reference model: a transfer starts at the edge ending an idle cycle in
    // which the value differs from the last one sent (or reset forced one),
    // and keeps the block busy for XFER cycles.
    logic [7:0] exp_q[$];
    logic [7:0] m_sent  = 8'h00;
    logic       m_force = 1'b1;
    int         m_rem   = 0;

    always @(posedge Clock) begin
        if (!rst_n) begin
            m_sent  <= 8'h00;
            m_force <= 1'b1;
            m_rem   <= 0;
        end else if (m_rem == 0) begin
            if (m_force || (data != m_sent)) begin
                m_force <= 1'b0;
                m_sent  <= data;
                m_rem   <= XFER;
                exp_q.push_back(data);
            end
        end else begin
            m_rem <= m_rem - 1;
        end
    end

    // Monitor: rebuilds each transfer from the serial pins.
    rec_t       got_q[$];
    logic [7:0] cur_word = 8'h00;
    int         cur_nbits = 0, cur_busy = 0, cur_latch = 0, cur_lp = 0;
    int         latch_total = 0, sclk_edges = 0;
    logic       prev_sclk = 1'b0, prev_latch = 1'b0;

    function automatic rec_t make_rec(logic [7:0] w, int nb, int bl, int ll, int lp);
        rec_t r;
        r.word = w; r.nbits = nb; r.busy_len = bl; r.latch_len = ll; r.latch_pulses = lp;
        return r;
    endfunction

    always @(negedge Clock) begin
        if (!rst_n) begin
            cur_word <= 8'h00; cur_nbits <= 0; cur_busy <= 0; cur_latch <= 0; cur_lp <= 0;
        end else if (done) begin
            got_q.push_back(make_rec(cur_word, cur_nbits, cur_busy, cur_latch, cur_lp));
            cur_word <= 8'h00; cur_nbits <= 0; cur_busy <= 0; cur_latch <= 0; cur_lp <= 0;
        end else begin
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                cur_word  <= {cur_word[6:0], sdata};
                cur_nbits <= cur_nbits + 1;
            end
            if (busy === 1'b1) cur_busy <= cur_busy + 1;
            if (latch === 1'b1) cur_latch <= cur_latch + 1;
            if (latch === 1'b1 && prev_latch === 1'b0) begin
                cur_lp      <= cur_lp + 1;
                latch_total <= latch_total + 1;
            end
        end
        if ((sclk === 1'b1 && prev_sclk === 1'b0) || (sclk === 1'b0 && prev_sclk === 1'b1))
            sclk_edges <= sclk_edges + 1;
        prev_sclk  <= sclk;
        prev_latch <= latch;
    end

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic wait_recs(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (got_q.size() >= n) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (!busy && !done && m_rem == 0) quiet++; else quiet = 0;
            if (quiet >= 3) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0; data = 8'hA5; data1 = 8'hFF;
        repeat (3) step();
        chk_cnt++;
        if ({sclk, sdata, latch, busy, done} !== 5'b0) begin
            $display("FAIL reset_outputs: got %b expected 00000", {sclk, sdata, latch, busy, done});
        end else pass_cnt++;
        chk_cnt++;
        if ({sclk1, sdata1, latch1, busy1, done1} !== 5'b0) begin
            $display("FAIL reset_outputs_div1: got %b expected 00000", {sclk1, sdata1, latch1, busy1, done1});
        end else pass_cnt++;
    endtask

    task automatic test_first_transfer();
        bit ok;
        int n = -1;
        got_q.delete(); exp_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sclk === 1'b1) begin n = i + 1; break; end
        end
        chk_cnt++;
        if (n !== CD + 1) $display("FAIL first_rise_latency: got %0d expected %0d", n, CD + 1);
        else pass_cnt++;
        wait_recs(1, 200, ok);
        chk_cnt++;
        if (!ok) $display("FAIL first_done: got timeout expected done pulse");
        else pass_cnt++;
        if (ok) begin
            chk_cnt++;
            if (got_q[0].word !== 8'hA5) $display("FAIL first_bits: got %02h expected a5", got_q[0].word);
            else pass_cnt++;
            chk_cnt++;
            if (got_q[0].nbits !== W) $display("FAIL first_nbits: got %0d expected %0d", got_q[0].nbits, W);
            else pass_cnt++;
            chk_cnt++;
            if (got_q[0].busy_len !== XFER) $display("FAIL first_busy_len: got %0d expected %0d", got_q[0].busy_len, XFER);
            else pass_cnt++;
            chk_cnt++;
            if (got_q[0].latch_len !== CD || got_q[0].latch_pulses !== 1)
                $display("FAIL first_latch: got width %0d pulses %0d expected width %0d pulses 1",
                         got_q[0].latch_len, got_q[0].latch_pulses, CD);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int e0 = sclk_edges;
        int busy_seen = 0;
        got_q.delete();
        repeat (200) begin
            step();
            if (busy !== 1'b0) busy_seen++;
        end
        chk_cnt++;
        if (sclk_edges - e0 !== 0) $display("FAIL hold_no_sclk: got %0d edges expected 0", sclk_edges - e0);
        else pass_cnt++;
        chk_cnt++;
        if (busy_seen !== 0 || got_q.size() !== 0)
            $display("FAIL hold_idle: got busy %0d xfers %0d expected 0 0", busy_seen, got_q.size());
        else pass_cnt++;
    endtask

    task automatic test_drop_intermediate();
        bit ok;
        logic [7:0] w0, w1;
        got_q.delete();
        data = 8'h01;
        repeat (3) step();
        repeat (20) step();
        data = 8'h02;
        repeat (10) step();
        data = 8'h03;
        wait_recs(2, 400, ok);
        repeat (100) step();
        w0 = (got_q.size() > 0) ? got_q[0].word : 8'hxx;
        w1 = (got_q.size() > 1) ? got_q[1].word : 8'hxx;
        chk_cnt++;
        if (got_q.size() !== 2) $display("FAIL drop_count: got %0d transfers expected 2", got_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (w0 !== 8'h01 || w1 !== 8'h03) $display("FAIL drop_words: got %02h %02h expected 01 03", w0, w1);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        bit ok;
        int lt0;
        logic pre_busy;
        got_q.delete();
        lt0 = latch_total;
        data = 8'h5A;
        for (int i = 0; i < 200 && cur_nbits < 4; i++) step();
        repeat (5) step();
        pre_busy = busy;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (pre_busy !== 1'b1 || {sclk, sdata, latch, busy, done} !== 5'b0)
            $display("FAIL abort_outputs: got busy_before %b outputs %b expected 1 00000",
                     pre_busy, {sclk, sdata, latch, busy, done});
        else pass_cnt++;
        repeat (3) step();
        chk_cnt++;
        if (latch_total !== lt0 || got_q.size() !== 0)
            $display("FAIL abort_no_latch: got latches %0d dones %0d expected 0 0", latch_total - lt0, got_q.size());
        else pass_cnt++;
        rst_n = 1'b1;
        wait_recs(1, 200, ok);
        chk_cnt++;
        if (!ok) $display("FAIL abort_refresh: got timeout expected transfer");
        else if (got_q[0].word !== 8'h5A || got_q[0].busy_len !== XFER || got_q[0].latch_pulses !== 1)
            $display("FAIL abort_refresh: got %02h busy %0d latches %0d expected 5a %0d 1",
                     got_q[0].word, got_q[0].busy_len, got_q[0].latch_pulses, XFER);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b0;
        logic [7:0] w0, w1;
        got_q.delete();
        data = 8'h3C;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        chk_cnt++;
        if (!ok || busy !== 1'b0) $display("FAIL b2b_done: got done %b busy %b expected 1 0", ok, busy);
        else pass_cnt++;
        data = 8'hC3;
        step();
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL b2b_busy_next: got %b expected 1", busy);
        else pass_cnt++;
        wait_recs(2, 200, ok);
        w0 = (got_q.size() > 0) ? got_q[0].word : 8'hxx;
        w1 = (got_q.size() > 1) ? got_q[1].word : 8'hxx;
        chk_cnt++;
        if (w0 !== 8'h3C || w1 !== 8'hC3) $display("FAIL b2b_words: got %02h %02h expected 3c c3", w0, w1);
        else pass_cnt++;
    endtask

    task automatic test_clkdiv1();
        int k = 0, errs = 0, dones = 0;
        logic [7:0] w = 8'h00;
        logic p = 1'b0;
        rst1_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (busy1 === 1'b1) begin
                if (sclk1 !== ((k < 2 * W) ? k[0] : 1'b0)) errs++;
                if (latch1 !== (k == 2 * W)) errs++;
                k++;
            end
            if (sclk1 === 1'b1 && p === 1'b0) w = {w[6:0], sdata1};
            if (done1 === 1'b1) dones++;
            p = sclk1;
        end
        chk_cnt++;
        if (k !== 2 * W + 1) $display("FAIL div1_busy_len: got %0d expected %0d", k, 2 * W + 1);
        else pass_cnt++;
        chk_cnt++;
        if (errs !== 0) $display("FAIL div1_toggle: got %0d bad cycles expected 0", errs);
        else pass_cnt++;
        chk_cnt++;
        if (w !== 8'hFF || dones !== 1) $display("FAIL div1_data: got %02h dones %0d expected ff 1", w, dones);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit ok;
        int werr = 0, terr = 0, n;
        wait_idle(300, ok);
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 2) != 0) data = 8'($urandom);
            repeat ($urandom_range(1, 120)) step();
        end
        wait_idle(600, ok);
        chk_cnt++;
        if (!ok) $display("FAIL rand_settle: got timeout expected idle");
        else pass_cnt++;
        chk_cnt++;
        if (got_q.size() !== exp_q.size() || got_q.size() == 0)
            $display("FAIL rand_count: got %0d transfers expected %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i].word !== exp_q[i]) werr++;
            if (got_q[i].busy_len !== XFER || got_q[i].latch_len !== CD || got_q[i].nbits !== W) terr++;
        end
        chk_cnt++;
        if (werr !== 0) $display("FAIL rand_words: got %0d wrong words expected 0", werr);
        else pass_cnt++;
        chk_cnt++;
        if (terr !== 0) $display("FAIL rand_timing: got %0d bad transfers expected 0", terr);
        else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset();
        test_first_transfer();
        test_hold();
        test_drop_intermediate();
        test_reset_abort();
        test_back_to_back();
        test_clkdiv1();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion (%0d/%0d so far)", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
